// File: rtl/cw_seq_pkg.sv
// rtl/cw_seq_pkg.sv - FSM states, watchdog limit and select-width helper for the crypto sequencer
package cw_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAITB = 3'd2,
    S_RUN   = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } seq_state_e;

  // Edges allowed in WAITB without seeing busy before the batch is aborted.
  localparam int WAIT_BUSY_MAX = 3;

  // Width of a core index; a single core still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cw_seq_core_mux.sv
// rtl/cw_seq_core_mux.sv - selects busy and ciphertext of the latched core index
module cw_seq_core_mux #(
  parameter int pNUM_CORES = 2,
  parameter int pCT_WIDTH  = 128,
  parameter int SW         = 1
) (
  input  logic [SW-1:0]                   sel,
  input  logic [pNUM_CORES-1:0]           core_busy,
  input  logic [pNUM_CORES*pCT_WIDTH-1:0] core_cipher,
  output logic                            busy,
  output logic [pCT_WIDTH-1:0]            cipher
);

  // An index with no matching core reads as idle with a zero ciphertext.
  always_comb begin
    busy   = 1'b0;
    cipher = '0;
    for (int k = 0; k < pNUM_CORES; k++) begin
      if (sel == SW'(k)) begin
        busy   = core_busy[k];
        cipher = core_cipher[k*pCT_WIDTH +: pCT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/cw_crypto_sequencer.sv
// rtl/cw_crypto_sequencer.sv - core select, batch, chaining and trigger sequencer (optional CW_SEQ_CYCLE_COUNTER_EN)
module cw_crypto_sequencer
  import cw_seq_pkg::*;
#(
  parameter int  pPT_WIDTH    = 128,
  parameter int  pCT_WIDTH    = 128,
  parameter int  pKEY_WIDTH   = 128,
  parameter int  pNUM_CORES   = 2,
  parameter int  pBATCH_WIDTH = 16,
  parameter int  pCNT_WIDTH   = 32,
  localparam int SW           = sel_width(pNUM_CORES)
) (
  input  logic                            crypto_clk,
  input  logic                            reset_i,
  input  logic                            I_start,
  input  logic [SW-1:0]                   I_core_sel,
  input  logic [pBATCH_WIDTH-1:0]         I_batch_count,
  input  logic                            I_chain,
  input  logic                            I_trig_per_op,
  input  logic [pPT_WIDTH-1:0]            I_textin,
  input  logic [pKEY_WIDTH-1:0]           I_key,
  output logic [pPT_WIDTH-1:0]            O_textout,
  output logic [pKEY_WIDTH-1:0]           O_keyout,
  output logic [pNUM_CORES-1:0]           O_core_start,
  input  logic [pNUM_CORES-1:0]           I_core_busy,
  input  logic [pNUM_CORES*pCT_WIDTH-1:0] I_core_cipher,
  output logic [pCT_WIDTH-1:0]            O_cipher,
  output logic                            O_busy,
  output logic                            O_done,
  output logic                            O_error,
  output logic                            O_trigger,
  output logic [pBATCH_WIDTH-1:0]         O_remaining,
  output logic [pCNT_WIDTH-1:0]           O_cycles
);

  localparam int                       WCW         = $clog2(WAIT_BUSY_MAX + 1);
  localparam logic [SW:0]              NUM_CORES_W = (SW+1)'(pNUM_CORES);
  localparam logic [pBATCH_WIDTH-1:0]  REM_ONE     = pBATCH_WIDTH'(1);

  seq_state_e              state_q, state_d;
  logic [SW-1:0]           sel_q;
  logic                    chain_q;
  logic                    trig_per_op_q;
  logic [WCW-1:0]          wait_cnt_q;

  logic                    accept;
  logic                    sel_bad;
  logic                    wd_expire;
  logic                    capture;
  logic                    relaunch;
  logic                    sel_oor;
  logic [SW-1:0]           launch_sel;
  logic                    trig_mode;
  logic [pNUM_CORES-1:0]   start_vec;
  logic [pBATCH_WIDTH-1:0] first_remaining;
  logic                    mux_busy;
  logic [pCT_WIDTH-1:0]    mux_cipher;

  cw_seq_core_mux #(
    .pNUM_CORES (pNUM_CORES),
    .pCT_WIDTH  (pCT_WIDTH),
    .SW         (SW)
  ) u_core_mux (
    .sel         (sel_q),
    .core_busy   (I_core_busy),
    .core_cipher (I_core_cipher),
    .busy        (mux_busy),
    .cipher      (mux_cipher)
  );

  // Configuration is not latched yet on the IDLE->LOAD edge, so use the live inputs there.
  assign sel_oor         = ({1'b0, I_core_sel} >= NUM_CORES_W);
  assign launch_sel      = (state_q == S_IDLE) ? I_core_sel : sel_q;
  assign trig_mode       = (state_q == S_IDLE) ? I_trig_per_op : trig_per_op_q;
  assign first_remaining = (I_batch_count == '0) ? '0 : I_batch_count - REM_ONE;

  // One-hot load pulse for whichever core is being launched.
  always_comb begin
    start_vec = '0;
    for (int k = 0; k < pNUM_CORES; k++) begin
      start_vec[k] = (launch_sel == SW'(k));
    end
  end

  // State register.
  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    sel_bad   = 1'b0;
    wd_expire = 1'b0;
    capture   = 1'b0;
    relaunch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_start) begin
          if (sel_oor) begin
            sel_bad = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD:  state_d = S_WAITB;
      S_WAITB: begin
        if (wait_cnt_q == WCW'(WAIT_BUSY_MAX)) begin
          wd_expire = 1'b1;
          state_d   = S_DONE;
        end else if (mux_busy) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!mux_busy) state_d = S_CAPT;
      end
      S_CAPT: begin
        capture = 1'b1;
        if (O_remaining != '0) begin
          relaunch = 1'b1;
          state_d  = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Batch configuration latched at start, and the busy-wait watchdog counter.
  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) begin
      sel_q         <= '0;
      chain_q       <= 1'b0;
      trig_per_op_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      if (accept) begin
        sel_q         <= I_core_sel;
        chain_q       <= I_chain;
        trig_per_op_q <= I_trig_per_op;
      end
      wait_cnt_q <= (state_q == S_WAITB && state_d == S_WAITB) ? wait_cnt_q + WCW'(1) : '0;
    end
  end

  // Text/key buses, captured ciphertext, remaining-op count and sticky error.
  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) begin
      O_textout   <= '0;
      O_keyout    <= '0;
      O_cipher    <= '0;
      O_remaining <= '0;
      O_error     <= 1'b0;
    end else begin
      if (accept) begin
        O_textout   <= I_textin;
        O_keyout    <= I_key;
        O_remaining <= first_remaining;
      end else if (relaunch) begin
        if (chain_q) O_textout <= pPT_WIDTH'(mux_cipher);
        O_remaining <= (O_remaining != '0) ? O_remaining - REM_ONE : '0;
      end
      if (capture) O_cipher <= mux_cipher;
      if (accept)                      O_error <= 1'b0;
      else if (sel_bad || wd_expire)   O_error <= 1'b1;
    end
  end

  // Status and strobe outputs registered from the next state so they line up with it.
  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) begin
      O_core_start <= '0;
      O_busy       <= 1'b0;
      O_done       <= 1'b0;
      O_trigger    <= 1'b0;
    end else begin
      O_core_start <= (state_d == S_LOAD) ? start_vec : '0;
      O_busy       <= (state_d != S_IDLE);
      O_done       <= (state_d == S_DONE);
      O_trigger    <= (state_d == S_LOAD) || (state_d == S_WAITB) || (state_d == S_RUN) ||
                      (!trig_mode && state_d == S_CAPT);
    end
  end

`ifdef CW_SEQ_CYCLE_COUNTER_EN
  logic [pCNT_WIDTH-1:0] cycles_q;

  // Saturating count of busy cycles, restarted by each accepted start.
  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i)                               cycles_q <= '0;
    else if (accept)                           cycles_q <= '0;
    else if (O_busy && (cycles_q != '1))       cycles_q <= cycles_q + pCNT_WIDTH'(1);
  end

  assign O_cycles = cycles_q;
`else
  assign O_cycles = '0;
`endif

endmodule

// File: tb/tb_cw_crypto_sequencer.sv
// tb/tb_cw_crypto_sequencer.sv - self-checking bench for cw_crypto_sequencer
module tb_cw_crypto_sequencer;

  localparam int NC = 2;
  localparam int CT = 128;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic            crypto_clk = 1'b0;
  logic            reset_i;
  logic            I_start;
  logic [0:0]      I_core_sel;
  logic [15:0]     I_batch_count;
  logic            I_chain;
  logic            I_trig_per_op;
  logic [127:0]    I_textin;
  logic [127:0]    I_key;
  logic [127:0]    O_textout;
  logic [127:0]    O_keyout;
  logic [NC-1:0]   O_core_start;
  logic [NC-1:0]   I_core_busy;
  logic [NC*CT-1:0] I_core_cipher;
  logic [127:0]    O_cipher;
  logic            O_busy;
  logic            O_done;
  logic            O_error;
  logic            O_trigger;
  logic [15:0]     O_remaining;
  logic [31:0]     O_cycles;

  int n_vec  = 0;
  int n_miss = 0;

  cw_crypto_sequencer dut (
    .crypto_clk    (crypto_clk),
    .reset_i       (reset_i),
    .I_start       (I_start),
    .I_core_sel    (I_core_sel),
    .I_batch_count (I_batch_count),
    .I_chain       (I_chain),
    .I_trig_per_op (I_trig_per_op),
    .I_textin      (I_textin),
    .I_key         (I_key),
    .O_textout     (O_textout),
    .O_keyout      (O_keyout),
    .O_core_start  (O_core_start),
    .I_core_busy   (I_core_busy),
    .I_core_cipher (I_core_cipher),
    .O_cipher      (O_cipher),
    .O_busy        (O_busy),
    .O_done        (O_done),
    .O_error       (O_error),
    .O_trigger     (O_trigger),
    .O_remaining   (O_remaining),
    .O_cycles      (O_cycles)
  );

  always #5 crypto_clk = ~crypto_clk;

  // Stand-in cipher: the FIPS-197 vector maps to its known answer, anything else to a core-tagged mix.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key, input int k);
    logic [31:0] salt;
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    salt = 32'h9e3779b9 + 32'(k);
    return {pt[95:0], pt[127:96]} ^ key ^ {4{salt}};
  endfunction

  // Core models: busy rises dly_cfg cycles after the load pulse is seen and lasts len_cfg cycles.
  int dly_cfg [NC];
  int len_cfg [NC];
  int idx     [NC];

  always @(posedge crypto_clk) begin
    for (int k = 0; k < NC; k++) begin
      if (O_core_start[k]) begin
        I_core_cipher[k*CT +: CT] <= core_fn(O_textout, O_keyout, k);
        I_core_busy[k]            <= (dly_cfg[k] == 0) && (len_cfg[k] > 0);
        idx[k]                    <= 1;
      end else if (idx[k] != 0) begin
        I_core_busy[k] <= (idx[k] >= dly_cfg[k]) && (idx[k] < dly_cfg[k] + len_cfg[k]);
        idx[k]         <= (idx[k] < dly_cfg[k] + len_cfg[k]) ? idx[k] + 1 : 0;
      end
    end
  end

  // Observation of pulses, trigger windows and per-launch bus values.
  int           n_start [NC];
  int           n_done;
  int           n_trig;
  bit           trig_prev = 1'b0;
  logic [127:0] launch_txt [$];
  int           launch_rem [$];

  always @(negedge crypto_clk) begin
    for (int k = 0; k < NC; k++) if (O_core_start[k]) n_start[k]++;
    if (O_core_start != '0) begin
      launch_txt.push_back(O_textout);
      launch_rem.push_back(int'(O_remaining));
    end
    if (O_done) n_done++;
    if (O_trigger && !trig_prev) n_trig++;
    trig_prev = O_trigger;
  end

  logic [127:0] model_cipher;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge crypto_clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int k = 0; k < NC; k++) n_start[k] = 0;
    n_done = 0;
    n_trig = 0;
    launch_txt.delete();
    launch_rem.delete();
  endtask

  task automatic wait_core_idle();
    int g;
    g = 0;
    while ((I_core_busy != '0 || idx[0] != 0 || idx[1] != 0) && g < 200) begin
      tick();
      g++;
    end
  endtask

  task automatic drive(input int sel, input int cnt, input bit chain, input bit per_op,
                       input logic [127:0] pt, input logic [127:0] key);
    I_core_sel    = 1'(sel);
    I_batch_count = 16'(cnt);
    I_chain       = chain;
    I_trig_per_op = per_op;
    I_textin      = pt;
    I_key         = key;
  endtask

  // Runs one batch and checks it against a model built from the batch rules.
  task automatic run_batch(input string tag, input int sel, input int cnt, input bit chain,
                           input bit per_op, input logic [127:0] pt, input logic [127:0] key,
                           input int poke);
    int           eff, ops, total, el, exp_cyc;
    bit           abort;
    logic [127:0] t, ct;
    logic [127:0] exp_txt [$];
    int           exp_rem [$];

    eff   = (cnt == 0) ? 1 : cnt;
    abort = (len_cfg[sel] == 0) || (dly_cfg[sel] >= 3);
    ops   = abort ? 1 : eff;
    t     = pt;
    for (int i = 0; i < ops; i++) begin
      exp_txt.push_back(t);
      exp_rem.push_back(eff - 1 - i);
      ct = core_fn(t, key, sel);
      if (!abort) model_cipher = ct;
      if (chain) t = ct;
    end
    total = abort ? 6 : eff * (len_cfg[sel] + dly_cfg[sel] + 3) + 1;
`ifdef CW_SEQ_CYCLE_COUNTER_EN
    exp_cyc = total;
`else
    exp_cyc = 0;
`endif

    wait_core_idle();
    clear_mon();
    drive(sel, cnt, chain, per_op, pt, key);
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    chk({tag, "/err_clr"}, O_error, 0);
    el = 0;
    while (O_busy && el < 2000) begin
      I_start = (el == poke);
      tick();
      el++;
    end
    I_start = 1'b0;

    chk({tag, "/latency"}, el, total);
    chk({tag, "/starts"}, n_start[sel], ops);
    chk({tag, "/other_core"}, n_start[1 - sel], 0);
    chk({tag, "/done"}, n_done, 1);
    chk({tag, "/error"}, O_error, abort ? 1 : 0);
    chk({tag, "/remaining"}, O_remaining, abort ? eff - 1 : 0);
    chk({tag, "/cipher"}, O_cipher, model_cipher);
    chk({tag, "/keyout"}, O_keyout, key);
    chk({tag, "/trig_win"}, n_trig, per_op ? ops : 1);
    chk({tag, "/cycles"}, O_cycles, exp_cyc);
    for (int i = 0; i < ops; i++) begin
      chk($sformatf("%s/txt%0d", tag, i), (i < launch_txt.size()) ? launch_txt[i] : 'x, exp_txt[i]);
      chk($sformatf("%s/rem%0d", tag, i), (i < launch_rem.size()) ? launch_rem[i] : -1, exp_rem[i]);
    end
  endtask

  int s;
  int exp_cyc_fips;

  initial begin
    reset_i       = 1'b1;
    I_start       = 1'b0;
    I_core_busy   = '0;
    I_core_cipher = '0;
    model_cipher  = '0;
    for (int k = 0; k < NC; k++) begin
      dly_cfg[k] = 0;
      len_cfg[k] = 4;
      idx[k]     = 0;
    end
    clear_mon();
    drive(0, 1, 1'b0, 1'b0, '0, '0);

    // Reset values, held and just after release.
    repeat (2) tick();
    chk("rst/core_start", O_core_start, 0);
    chk("rst/busy", O_busy, 0);
    chk("rst/textout", O_textout, 0);
    chk("rst/cipher", O_cipher, 0);
    reset_i = 1'b0;
    tick();
    chk("rst/done", O_done, 0);
    chk("rst/error", O_error, 0);
    chk("rst/trigger", O_trigger, 0);
    chk("rst/remaining", O_remaining, 0);
    chk("rst/cycles", O_cycles, 0);

    // FIPS-197 single operation with a 10-cycle core.
    dly_cfg[0] = 0;
    len_cfg[0] = 10;
    run_batch("fips", 0, 1, 1'b0, 1'b0, FIPS_PT, FIPS_KEY, -1);
    chk("fips/known_ct", O_cipher, FIPS_CT);
`ifdef CW_SEQ_CYCLE_COUNTER_EN
    exp_cyc_fips = 14;
`else
    exp_cyc_fips = 0;
`endif
    chk("fips/cycles14", O_cycles, exp_cyc_fips);

    // Chained batch of 3; a start pulse during RUN of the first op must be ignored.
    run_batch("chain", 0, 3, 1'b1, 1'b0, FIPS_PT, FIPS_KEY, 5);
    chk("chain/op2_text", (launch_txt.size() > 1) ? launch_txt[1] : 'x, FIPS_CT);

    // Watchdog: core 0 never raises busy; error lands exactly at edge 5.
    wait_core_idle();
    len_cfg[0] = 0;
    clear_mon();
    drive(0, 2, 1'b0, 1'b0, FIPS_PT, FIPS_KEY);
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    repeat (4) tick();
    chk("wd/edge4_error", O_error, 0);
    chk("wd/edge4_busy", O_busy, 1);
    tick();
    chk("wd/edge5_error", O_error, 1);
    chk("wd/edge5_done", O_done, 1);
    tick();
    chk("wd/idle_busy", O_busy, 0);
    chk("wd/idle_trigger", O_trigger, 0);
    chk("wd/done_count", n_done, 1);
    chk("wd/remaining", O_remaining, 1);
    len_cfg[0] = 10;

    // Core 1, per-op trigger, batch 2; also clears the sticky error.
    dly_cfg[1] = 1;
    len_cfg[1] = 4;
    run_batch("sel1", 1, 2, 1'b0, 1'b1, FIPS_PT ^ 128'h5a, FIPS_KEY, -1);

    // Batch count 0 behaves as a single operation.
    run_batch("cnt0", 1, 0, 1'b1, 1'b0, 128'hdeadbeef, 128'h1234, -1);

    // Randomised batches, including late-busy and no-busy cores.
    for (int r = 0; r < 10; r++) begin
      s          = $urandom_range(0, 1);
      dly_cfg[s] = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      len_cfg[s] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      run_batch($sformatf("rand%0d", r), s, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, -1);
    end

    // Reset in the middle of RUN drops everything at once and nothing relaunches.
    dly_cfg[0] = 0;
    len_cfg[0] = 10;
    wait_core_idle();
    clear_mon();
    drive(0, 3, 1'b1, 1'b0, FIPS_PT, FIPS_KEY);
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    repeat (5) tick();
    chk("mrst/pre_busy", O_busy, 1);
    #2 reset_i = 1'b1;
    #1;
    chk("mrst/busy", O_busy, 0);
    chk("mrst/trigger", O_trigger, 0);
    chk("mrst/core_start", O_core_start, 0);
    chk("mrst/remaining", O_remaining, 0);
    chk("mrst/textout", O_textout, 0);
    tick();
    reset_i = 1'b0;
    repeat (20) tick();
    chk("mrst/no_relaunch", n_start[0], 1);
    chk("mrst/idle", O_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cw_crypto_sequencer.md
# cw_crypto_sequencer

Parametrised crypto-core sequencer between the register block and one or more crypto cores, all in the `crypto_clk` domain. It replaces fixed single-core glue with four capabilities:
- selection of one of `pNUM_CORES` cores;
- batch runs of up to 2^`pBATCH_WIDTH`−1 back-to-back operations;
- optional ciphertext chaining;
- programmable trigger mode, core-handshake watchdog and optional cycle counter.

## Interface
Parameters:
- `pPT_WIDTH`, 128, plaintext width.
- `pCT_WIDTH`, 128, ciphertext width; must equal `pPT_WIDTH` when chaining is used.
- `pKEY_WIDTH`, 128, key width.
- `pNUM_CORES`, 2, number of attached cores (≥1).
- `pBATCH_WIDTH`, 16, batch-count width.
- `pCNT_WIDTH`, 32, cycle-counter width.

Ports (`SW` = max(1, $clog2(`pNUM_CORES`))):
- `crypto_clk`  in  1  sole clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `I_start`  in  1  one-cycle start request from the register block.
- `I_core_sel`  in  `SW`  core index, sampled at start.
- `I_batch_count`  in  `pBATCH_WIDTH`  number of operations; 0 is treated as 1; sampled at start.
- `I_chain`  in  1  1 = the previous ciphertext is the next plaintext; sampled at start.
- `I_trig_per_op`  in  1  0 = one trigger window per batch, 1 = one window per operation; sampled at start.
- `I_textin`  in  `pPT_WIDTH`  initial plaintext.
- `I_key`  in  `pKEY_WIDTH`  key.
- `O_textout`  out  `pPT_WIDTH`  plaintext bus shared by all cores.
- `O_keyout`  out  `pKEY_WIDTH`  key bus shared by all cores.
- `O_core_start`  out  `pNUM_CORES`  one-hot load pulse.
- `I_core_busy`  in  `pNUM_CORES`  per-core busy.
- `I_core_cipher`  in  `pNUM_CORES*pCT_WIDTH`  packed ciphertexts; core k occupies bits [k*`pCT_WIDTH` +: `pCT_WIDTH`].
- `O_cipher`  out  `pCT_WIDTH`  last captured ciphertext.
- `O_busy`  out  1  high from LOAD until the return to IDLE.
- `O_done`  out  1  one-cycle pulse at batch end.
- `O_error`  out  1  sticky watchdog flag; cleared by the next accepted start.
- `O_trigger`  out  1  registered scope trigger.
- `O_remaining`  out  `pBATCH_WIDTH`  operations still to launch.
- `O_cycles`  out  `pCNT_WIDTH`  busy-cycle count.

## Operation
FSM states: IDLE, LOAD, WAITB, RUN, CAPT, DONE.
- **IDLE**:
  - `I_start` is accepted only in IDLE; starts in any other state are ignored.
  - On an accepted start: latch `I_core_sel`, batch count (0→1), `I_chain`, `I_trig_per_op`; load `O_textout`←`I_textin` and `O_keyout`←`I_key`; clear `O_error`; go to LOAD.
  - An out-of-range `I_core_sel` (≥`pNUM_CORES`) sets `O_error` and the FSM stays in IDLE.
- **LOAD**: assert `O_core_start[sel]` for exactly one cycle, decrement `O_remaining`, go to WAITB.
- **WAITB**:
  - `I_core_busy[sel]` high → RUN.
  - After 3 cycles without busy → set `O_error`, go to DONE (batch aborted).
- **RUN**: `I_core_busy[sel]` low → CAPT.
- **CAPT**:
  - Always: `O_cipher` ← selected ciphertext.
  - `O_remaining` > 0 and chaining on: `O_textout` ← that ciphertext, go to LOAD.
  - `O_remaining` > 0 and chaining off: `O_textout` is unchanged, go to LOAD.
  - `O_remaining` = 0: go to DONE.
- **DONE**: pulse `O_done`, go to IDLE.
- **Trigger**:
  - Per-batch mode: `O_trigger` is high from LOAD of the first operation through the CAPT of the last.
  - Per-op mode: `O_trigger` is high in LOAD/WAITB/RUN of each operation and low in CAPT.
- **Reset values**:
  - All outputs 0; the FSM is in IDLE.
  - `reset_i` mid-operation drops `O_core_start`, `O_trigger` and `O_busy` asynchronously.
  - The attached core is not reset by this block.

## Timing
- `I_start` sampled high at edge 0 → LOAD during cycle 1, `O_core_start` high during cycle 1 only, `O_busy` high from cycle 1.
- The core must raise busy at one of edges 2–4; busy first seen at edge 5 is too late and is an error.
- Busy sampled low at edge E → `O_cipher` valid after edge E+1 (CAPT).
- Relaunch pulse in cycle E+2.
- Final operation: `O_done` high in cycle E+2; `O_busy` low from E+3.
- Per-operation overhead beyond core latency: 3 cycles (LOAD, CAPT, plus the busy-detect edge).
- `O_remaining` arithmetic saturates at 0 and never wraps.

## Configuration
- `CW_SEQ_CYCLE_COUNTER_EN` defined:
  - `O_cycles` is cleared on an accepted start.
  - It increments every cycle `O_busy` is high, saturates at all-ones and holds after DONE.
- Not defined: `O_cycles` is tied to 0 and no counter logic is synthesised.

## Structure
- Package `cw_seq_pkg` holds:
  - the FSM state enum;
  - localparam `WAIT_BUSY_MAX` = 3;
  - a `sel_width(n)` function.
- Sub-module `cw_seq_core_mux`: combinational selection of busy and ciphertext by the latched index. It is the only place `I_core_cipher` is unpacked.

## Test plan
- FIPS-197 run: key 000102…0f, pt 00112233…ff, core 0 modelled with 10-cycle busy, batch 1.
  - `O_cipher` = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `O_done` exactly 1 pulse; `O_cycles` = 14.
- Chained batch: batch 3, chain 1, same key/pt.
  - Three `O_core_start` pulses.
  - Second operation's `O_textout` = 69c4e0d8…c55a.
  - `O_remaining` goes 2→1→0; one `O_done`.
- Watchdog: core never raises busy.
  - `O_error` = 1 at edge 5; `O_done` pulses; FSM back in IDLE.
  - The next start clears `O_error`.
- Core select and trigger mode: sel = 1, per-op trigger, batch 2.
  - Only `O_core_start[1]` pulses; core 0 is ignored.
  - `O_trigger` shows 2 separate windows.
- `I_start` re-asserted during RUN is ignored.
- `reset_i` asserted mid-RUN: all outputs 0 immediately, with no further `O_core_start`.
